vde_cmd_arbiter: RTL and testbench

VDE_CMD_ARBITER -- requirements
Module: vde_cmd_arbiter

---
 rtl/vde_cmd_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_vde_cmd_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vde_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vde_cmd_arbiter
// Purpose  : Round-robin command FIFO feeding a heap, with one held multi-bump
//            and one coalesced decay; optional stats under VDE_CMD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vde_cmd_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int VAR_W      = 32,
    parameter int BUMP_LANES = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [NUM_PORTS-1:0]               in_valid,
    output logic [NUM_PORTS-1:0]               in_ready,
    input  logic [NUM_PORTS*2-1:0]             in_op,
    input  logic [NUM_PORTS*VAR_W-1:0]         in_var,
    input  logic [NUM_PORTS-1:0]               in_val,
    input  logic [$clog2(BUMP_LANES+1)-1:0]    bump_count,
    input  logic [BUMP_LANES*VAR_W-1:0]        bump_vars,
    output logic                               bump_ready,
    input  logic                               decay,
    input  logic                               heap_busy,
    output logic                               h_valid,
    output logic [1:0]                         h_op,
    output logic [VAR_W-1:0]                   h_var,
    output logic                               h_val,
    output logic [$clog2(BUMP_LANES+1)-1:0]    h_bump_count,
    output logic [BUMP_LANES*VAR_W-1:0]        h_bump_vars,
    output logic                               h_decay,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               bad_op
`ifdef VDE_CMD_STATS_EN
    ,
    output logic [31:0]                        stat_issued,
    output logic [31:0]                        stat_decay_merged,
    output logic [31:0]                        stat_starve_hits
`endif
);

    localparam int CW = $clog2(BUMP_LANES+1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int EW = VAR_W + 3;
    localparam int SW = $clog2(STARVE_MAX+1);
    localparam logic [LW-1:0] FULL_LEVEL   = LW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);
    localparam logic [PW:0]   NP           = (PW+1)'(NUM_PORTS);
    localparam logic [1:0]    OP_ILLEGAL   = 2'b11;

    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;
    logic [PW-1:0]             rr_q, rr_d;
    logic                      bump_held_q, bump_held_d;
    logic [CW-1:0]             bump_cnt_q, bump_cnt_d;
    logic [BUMP_LANES*VAR_W-1:0] bump_vars_q, bump_vars_d;
    logic                      decay_held_q, decay_held_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      bad_q, bad_d;

    logic                      grant_found;
    logic [PW-1:0]             grant_idx;
    logic [PW:0]               cand;
    logic [1:0]                sel_op;
    logic [VAR_W-1:0]          sel_var;
    logic                      sel_val;
    logic                      port_open, accept, push, pop;
    logic                      can_issue, pending, starve_hit;
    logic                      issue_fifo, issue_bump, issue_decay;
    logic                      bump_take;
    logic [EW-1:0]             head;

    // Search starts at rr_q, which always holds the port after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_q} + (PW+1)'(i);
            if (cand >= NP) cand = cand - NP;
            if (!grant_found && in_valid[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        can_issue   = rst_n && !flush && !heap_busy;
        pending     = bump_held_q || decay_held_q;
        starve_hit  = pending && (starve_q == STARVE_LIMIT);
        issue_fifo  = 1'b0;
        issue_bump  = 1'b0;
        issue_decay = 1'b0;
        if (can_issue) begin
            if (starve_hit) begin
                if (bump_held_q) issue_bump = 1'b1;
                else             issue_decay = 1'b1;
            end else if (level_q != '0) begin
                issue_fifo = 1'b1;
            end else if (bump_held_q) begin
                issue_bump = 1'b1;
            end else if (decay_held_q) begin
                issue_decay = 1'b1;
            end
        end
        pop = issue_fifo;
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        port_open = grant_found && rst_n && !flush && ((level_q != FULL_LEVEL) || pop);
        sel_op    = '0;
        sel_var   = '0;
        sel_val   = 1'b0;
        in_ready  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == PW'(p)) begin
                sel_op      = in_op[p*2 +: 2];
                sel_var     = in_var[p*VAR_W +: VAR_W];
                sel_val     = in_val[p];
                in_ready[p] = port_open;
            end
        end
        accept = port_open;
        push   = accept && (sel_op != OP_ILLEGAL);
    end

    assign head         = mem_q[rd_ptr_q];
    assign h_valid      = issue_fifo;
    assign h_op         = issue_fifo ? head[EW-1 -: 2] : 2'b00;
    assign h_val        = issue_fifo ? head[VAR_W] : 1'b0;
    assign h_var        = issue_fifo ? head[VAR_W-1:0] : '0;
    assign h_bump_count = issue_bump ? bump_cnt_q : '0;
    assign h_bump_vars  = issue_bump ? bump_vars_q : '0;
    assign h_decay      = issue_decay;
    assign fifo_level   = level_q;
    assign bad_op       = bad_q;
    assign bump_ready   = rst_n && !flush && (!bump_held_q || issue_bump);
    assign bump_take    = bump_ready && (bump_count != '0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        level_d      = level_q + LW'(push) - LW'(pop);
        rr_d         = rr_q;
        if (accept) rr_d = (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + PW'(1);
        bump_held_d  = bump_held_q && !issue_bump;
        bump_cnt_d   = bump_cnt_q;
        bump_vars_d  = bump_vars_q;
        if (bump_take) begin
            bump_held_d = 1'b1;
            bump_cnt_d  = bump_count;
            bump_vars_d = bump_vars;
        end
        decay_held_d = (decay_held_q && !issue_decay) || decay;
        starve_d     = starve_q;
        if (issue_bump || issue_decay)  starve_d = '0;
        else if (issue_fifo && pending) starve_d = starve_q + SW'(1);
        bad_d        = bad_q || (accept && (sel_op == OP_ILLEGAL));
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            rr_d         = '0;
            bump_held_d  = 1'b0;
            bump_cnt_d   = '0;
            bump_vars_d  = '0;
            decay_held_d = 1'b0;
            starve_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rr_q         <= '0;
            bump_held_q  <= 1'b0;
            bump_cnt_q   <= '0;
            bump_vars_q  <= '0;
            decay_held_q <= 1'b0;
            starve_q     <= '0;
            bad_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            rr_q         <= rr_d;
            bump_held_q  <= bump_held_d;
            bump_cnt_q   <= bump_cnt_d;
            bump_vars_q  <= bump_vars_d;
            decay_held_q <= decay_held_d;
            starve_q     <= starve_d;
            bad_q        <= bad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {sel_op, sel_val, sel_var};
    end

`ifdef VDE_CMD_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_merged_q, stat_merged_d;
    logic [31:0] stat_starve_q, stat_starve_d;

    // Counters saturate at all-ones and are unaffected by flush.
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_merged_d = stat_merged_q;
        stat_starve_d = stat_starve_q;
        if ((issue_fifo || issue_bump || issue_decay) && (stat_issued_q != '1))
            stat_issued_d = stat_issued_q + 32'd1;
        if (decay && decay_held_q && !issue_decay && !flush && (stat_merged_q != '1))
            stat_merged_d = stat_merged_q + 32'd1;
        if (starve_hit && (issue_bump || issue_decay) && (stat_starve_q != '1))
            stat_starve_d = stat_starve_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_merged_q <= '0;
            stat_starve_q <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_merged_q <= stat_merged_d;
            stat_starve_q <= stat_starve_d;
        end
    end

    assign stat_issued       = stat_issued_q;
    assign stat_decay_merged = stat_merged_q;
    assign stat_starve_hits  = stat_starve_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_vde_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vde_cmd_arbiter
// Purpose  : Directed vector table plus multi-cycle sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vde_cmd_arbiter;
    localparam int VW = 32;
    localparam int BL = 8;
    localparam int CW = 4;
    localparam int LW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, flush, decay, heap_busy;
    logic [1:0]       in_valid, in_ready, in_val;
    logic [3:0]       in_op;
    logic [2*VW-1:0]  in_var;
    logic [CW-1:0]    bump_count, h_bump_count;
    logic [BL*VW-1:0] bump_vars, h_bump_vars;
    logic             bump_ready, h_valid, h_val, h_decay, bad_op;
    logic [1:0]       h_op;
    logic [VW-1:0]    h_var;
    logic [LW-1:0]    fifo_level;
`ifdef VDE_CMD_STATS_EN
    logic [31:0]      stat_issued, stat_decay_merged, stat_starve_hits;
`endif

    int checks = 0;
    int errors = 0;

    vde_cmd_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_var(in_var), .in_val(in_val),
        .bump_count(bump_count), .bump_vars(bump_vars), .bump_ready(bump_ready),
        .decay(decay), .heap_busy(heap_busy),
        .h_valid(h_valid), .h_op(h_op), .h_var(h_var), .h_val(h_val),
        .h_bump_count(h_bump_count), .h_bump_vars(h_bump_vars), .h_decay(h_decay),
        .fifo_level(fifo_level), .bad_op(bad_op)
`ifdef VDE_CMD_STATS_EN
        , .stat_issued(stat_issued), .stat_decay_merged(stat_decay_merged),
        .stat_starve_hits(stat_starve_hits)
`endif
    );

    typedef struct {
        logic       rst_n, flush;
        logic [1:0] valid, op0, op1, val;
        logic [7:0] var0, var1, bvar;
        logic [3:0] bcnt;
        logic       decay, busy;
        logic [1:0] e_rdy;
        logic       e_brdy, e_hv;
        logic [1:0] e_hop;
        logic [7:0] e_hvar;
        logic       e_hval;
        logic [3:0] e_hbc;
        logic [7:0] e_hbv;
        logic       e_hdec;
        logic [6:0] e_lvl;
        logic       e_bad;
    } vec_t;

    vec_t tv[$];

    task automatic add(
        input logic r, input logic f, input logic [1:0] v, input logic [1:0] o0,
        input logic [1:0] o1, input logic [7:0] a0, input logic [7:0] a1,
        input logic [1:0] vl, input logic [3:0] bc, input logic [7:0] bv,
        input logic dc, input logic bz,
        input logic [1:0] erdy, input logic ebrdy, input logic ehv, input logic [1:0] ehop,
        input logic [7:0] ehvar, input logic ehval, input logic [3:0] ehbc,
        input logic [7:0] ehbv, input logic ehdec, input logic [6:0] elvl, input logic ebad);
        vec_t t;
        t.rst_n = r;  t.flush = f;  t.valid = v;  t.op0 = o0;  t.op1 = o1;
        t.var0 = a0;  t.var1 = a1;  t.val = vl;   t.bcnt = bc; t.bvar = bv;
        t.decay = dc; t.busy = bz;
        t.e_rdy = erdy;   t.e_brdy = ebrdy; t.e_hv = ehv;   t.e_hop = ehop;
        t.e_hvar = ehvar; t.e_hval = ehval; t.e_hbc = ehbc; t.e_hbv = ehbv;
        t.e_hdec = ehdec; t.e_lvl = elvl;   t.e_bad = ebad;
        tv.push_back(t);
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = '0; in_op = '0; in_var = '0; in_val = '0;
        bump_count = '0; bump_vars = '0; decay = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        logic [307:0] act, exp;
        rst_n = t.rst_n; flush = t.flush; in_valid = t.valid;
        in_op = {t.op1, t.op0};
        in_var = {24'd0, t.var1, 24'd0, t.var0};
        in_val = t.val; bump_count = t.bcnt;
        bump_vars = {248'd0, t.bvar};
        decay = t.decay; heap_busy = t.busy;
        #4;
        act = {in_ready, bump_ready, h_valid, h_op, h_var, h_val, h_bump_count,
               h_bump_vars, h_decay, fifo_level, bad_op};
        exp = {t.e_rdy, t.e_brdy, t.e_hv, t.e_hop, 24'd0, t.e_hvar, t.e_hval, t.e_hbc,
               248'd0, t.e_hbv, t.e_hdec, t.e_lvl, t.e_bad};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d: got rdy=%b brdy=%b hv=%b op=%b var=%h val=%b bc=%h bv=%h dec=%b lvl=%0d bad=%b expected rdy=%b brdy=%b hv=%b op=%b var=%h val=%b bc=%h bv=%h dec=%b lvl=%0d bad=%b",
                     idx, in_ready, bump_ready, h_valid, h_op, h_var, h_val, h_bump_count,
                     h_bump_vars[31:0], h_decay, fifo_level, bad_op,
                     t.e_rdy, t.e_brdy, t.e_hv, t.e_hop, t.e_hvar, t.e_hval, t.e_hbc,
                     t.e_hbv, t.e_hdec, t.e_lvl, t.e_bad);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fifo_issues;
        int decay_seen;
        bit found;

        //   rst fl valid op0    op1    var0   var1   val    bcnt  bvar   dc bz | rdy   brdy hv hop    hvar   hval hbc   hbv    hdec lvl bad
        add(0, 0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h21, 2'b11, 4'd3, 8'hAA, 1, 0,  2'b00, 0, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
        add(1, 0, 2'b11, 2'b00, 2'b01, 8'h10, 8'h21, 2'b01, 4'd0, 8'h00, 0, 1,  2'b01, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
        add(1, 0, 2'b11, 2'b00, 2'b01, 8'h10, 8'h21, 2'b01, 4'd0, 8'h00, 0, 1,  2'b10, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 1, 0);
        add(1, 0, 2'b11, 2'b00, 2'b01, 8'h10, 8'h21, 2'b01, 4'd0, 8'h00, 0, 1,  2'b01, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 2, 0);
        add(1, 0, 2'b11, 2'b00, 2'b01, 8'h10, 8'h21, 2'b01, 4'd0, 8'h00, 0, 1,  2'b10, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 3, 0);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 1, 2'b00, 8'h10, 1, 4'd0, 8'h00, 0, 4, 0);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 1, 2'b01, 8'h21, 0, 4'd0, 8'h00, 0, 3, 0);
        add(1, 0, 2'b10, 2'b00, 2'b11, 8'h00, 8'h99, 2'b00, 4'd0, 8'h00, 0, 1,  2'b10, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 2, 0);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 1,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 2, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 1, 2'b00, 8'h10, 1, 4'd0, 8'h00, 0, 2, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 1, 2'b01, 8'h21, 0, 4'd0, 8'h00, 0, 1, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 1);
        add(1, 0, 2'b01, 2'b10, 2'b00, 8'h33, 8'h00, 2'b00, 4'd2, 8'hB0, 1, 1,  2'b01, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 1, 1,  2'b00, 0, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 1, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd5, 8'hEE, 0, 0,  2'b00, 0, 1, 2'b10, 8'h33, 0, 4'd0, 8'h00, 0, 1, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd2, 8'hB0, 0, 0, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 1, 0,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 1, 0, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 1, 0, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 1);
        add(1, 0, 2'b01, 2'b00, 2'b00, 8'h44, 8'h00, 2'b00, 4'd1, 8'hC1, 1, 1,  2'b01, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 1);
        add(1, 1, 2'b01, 2'b00, 2'b00, 8'h45, 8'h00, 2'b00, 4'd3, 8'hC3, 1, 0,  2'b00, 0, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 1, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 1);
        add(1, 0, 2'b11, 2'b00, 2'b00, 8'h55, 8'h66, 2'b01, 4'd0, 8'h00, 0, 1,  2'b01, 1, 0, 2'b00, 8'h00, 0, 4'd0, 8'h00, 0, 0, 1);
        add(1, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 4'd0, 8'h00, 0, 0,  2'b00, 1, 1, 2'b00, 8'h55, 1, 4'd0, 8'h00, 0, 1, 1);

        rst_n = 1'b0; heap_busy = 1'b0; idle();
        tick(); tick();
        foreach (tv[i]) run_vec(i, tv[i]);

        // Fill to capacity while the heap stalls, then pop and push together.
        idle(); flush = 1'b1; heap_busy = 1'b1; tick();
        flush = 1'b0; in_valid = 2'b01;
        for (int i = 0; i < 64; i++) begin
            in_var = {32'd0, 32'(i)};
            tick();
        end
        in_var = {32'd0, 32'd99};
        #4;
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_level", 64'(fifo_level), 64'd64);
        tick();
        heap_busy = 1'b0;
        #4;
        check("full_pop_valid", 64'(h_valid), 64'd1);
        check("full_pop_var", 64'(h_var), 64'd0);
        check("full_push_ready", 64'(in_ready), 64'd1);
        tick();
        heap_busy = 1'b1; in_var = {32'd0, 32'd100};
        #4;
        check("full_level_after", 64'(fifo_level), 64'd64);
        check("full_ready_after", 64'(in_ready), 64'd0);
        tick();
        in_valid = '0; heap_busy = 1'b0;
        #4;
        check("full_next_head", 64'(h_var), 64'd1);
        tick();

        // A held bump must break through after STARVE_MAX FIFO issues.
        idle(); flush = 1'b1; heap_busy = 1'b1; tick();
        flush = 1'b0; in_valid = 2'b01;
        for (int i = 0; i < 40; i++) begin
            in_var = {32'd0, 32'(1000 + i)};
            tick();
        end
        in_valid = '0; bump_count = 4'd4; bump_vars = {248'd0, 8'hD4};
        #4;
        check("bump_accept", 64'(bump_ready), 64'd1);
        tick();
        bump_count = '0; bump_vars = '0; heap_busy = 1'b0;
        fifo_issues = 0; found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            #4;
            if (h_bump_count != '0) begin
                found = 1'b1;
                check("starve_fifo_issues", 64'(fifo_issues), 64'd16);
                check("starve_bump_hvalid", 64'(h_valid), 64'd0);
                check("starve_bump_count", 64'(h_bump_count), 64'd4);
                check("starve_bump_lane0", 64'(h_bump_vars[31:0]), 64'hD4);
                check("starve_level", 64'(fifo_level), 64'd24);
            end else if (h_valid) begin
                fifo_issues++;
            end
            tick();
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL starve_timeout: got no bump issue expected one within 100 cycles");
        end
        #4;
        check("starve_resume_var", 64'(h_var), 64'd1016);
        tick();

        // Decay pulses during a stall collapse into one issue.
        idle(); flush = 1'b1; heap_busy = 1'b1; tick();
        flush = 1'b0;
        decay = 1'b1; tick();
        decay = 1'b0; tick();
        decay = 1'b1; tick();
        decay = 1'b1; tick();
        decay = 1'b0;
        #4;
        check("decay_hold_busy", 64'(h_decay), 64'd0);
        tick();
        heap_busy = 1'b0; decay_seen = 0;
        for (int c = 0; c < 6; c++) begin
            #4;
            if (h_decay) decay_seen++;
            tick();
        end
        check("decay_coalesced", 64'(decay_seen), 64'd1);
        check("bad_op_final", 64'(bad_op), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
